byte_encode_stream: RTL and testbench
=====================================

# byte_encode_stream

Streaming, parametrised ByteEncode_d packer for the Kyber datapath. It accepts one polynomial of N_COEFF coefficients, each d bits wide with d selected per run (1..D_MAX, e.g. 1/4/10/12), over a valid/ready input. It emits the little-endian bit-packed byte string (32·d bytes for N_COEFF=256) over a valid/ready byte output. It supersedes the flat bit-array-to-byte-array conversion in decryption/encryption: the same bit order, but streamed, with backpressure and variable symbol width.

## Interface
- N_COEFF, 256, coefficients per run; must be a multiple of 8.
- D_MAX, 12, maximum coefficient width.
- ACC_W, D_MAX+7, accumulator width in bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; honoured only in IDLE.
- d_sel  in  4  coefficient width d for the run; sampled on start.
- err  out  1  one-cycle pulse: start was given with d_sel==0 or d_sel>D_MAX.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- coeff_valid  in  1  input coefficient is valid.
- coeff_ready  out  1  block can accept a coefficient.
- coeff_data  in  D_MAX  coefficient; bits [D_MAX-1:d] are ignored (masked).
- byte_valid  out  1  byte_data is valid.
- byte_ready  in  1  downstream accepts the byte.
- byte_data  out  8  packed output byte.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start with a valid d_sel: latch d, clear acc, fill and coeff_cnt, go to LOAD.
  - start with an invalid d_sel: pulse err, stay in IDLE.
- LOAD:
  - coeff_ready = (fill < 8). On a coeff handshake: acc |= (coeff_data & mask_d) << fill; fill += d; coeff_cnt++.
  - When coeff_cnt reaches N_COEFF, go to DRAIN.
- Byte emission (LOAD and DRAIN):
  - byte_valid = (fill >= 8); byte_data = acc[7:0].
  - On a byte handshake: acc >>= 8; fill -= 8.
  - Coefficient intake and byte emission are mutually exclusive by construction, because fill<8 and fill>=8 cannot both hold.
- DRAIN: coeff_ready=0. When fill==0, go to DONE.
  - N_COEFF·d is always a multiple of 8, so no partial byte remains.
- DONE: done=1 for one cycle, then go to IDLE.
- Bit order: stream bit k = bit (k mod d) of coefficient ⌊k/d⌋. Bit j of output byte i is stream bit 8i+j.
- Width rules:
  - fill is at most 7+D_MAX, which fits ACC_W.
  - fill is 5 bits; coeff_cnt is $clog2(N_COEFF+1) bits.
- Backpressure: while byte_valid=1 and byte_ready=0, byte_data and all state hold stable.
- start while busy is ignored. d_sel is ignored outside the start cycle.
- rst at any time, including mid-run, returns the block to IDLE with acc, fill and counters cleared. No done pulse is generated for the aborted run.

## Timing
- Reset values: coeff_ready=0, byte_valid=0, byte_data=0, busy=0, done=0, err=0.
- start at cycle t gives busy=1 and coeff_ready=1 from t+1.
- err pulses at t+1.
- Outputs are decoded from registered state, with no combinational path from inputs to outputs.
- First byte_valid appears one cycle after the coeff handshake that makes fill>=8.
- With no backpressure:
  - d=12: a 5-cycle repeat of coeff, byte, coeff, byte, byte.
  - d=1: 9 cycles per byte.
- The last byte handshake at cycle T gives done=1 at T+1, busy=0 at T+2, and a new start is accepted from T+2.

## Structure
- Shared package kyber_pkg holds:
  - N_COEFF and D_MAX constants.
  - A state enum typedef for IDLE/LOAD/DRAIN/DONE.
  - A function computing mask_d from d.
- No sub-module: a single module containing the FSM, accumulator and counters.

## Test plan
- d=12, coeffs 0x123 then 0x456 -> bytes 0x23, 0x61, 0x45. A full run of 256 coeffs yields 384 bytes, followed by a single done pulse.
- d=4, coeffs 0x1, 0x2, 0xFF3, 0x4 -> bytes 0x21, 0x43, confirming upper-bit masking. A full run yields 128 bytes.
- d=1, alternating 1,0 -> every byte 0x55, 32 bytes total. Check the 9-cycle/byte cadence.
- Random byte_ready (about 30% low) with d=10 -> 320 bytes matching the reference model. byte_data is stable while stalled, and coeff_ready=0 whenever fill>=8.
- start with d_sel=0 and with d_sel=13 -> err pulse, busy stays 0, no handshakes. start with d_sel=5 while busy -> ignored.
- rst asserted mid-run (after 100 coeffs, d=10) -> all outputs at reset values immediately. A following d=10 run produces exactly 320 correct bytes.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber datapath constants, FSM state encoding and the coefficient mask helper.
package kyber_pkg;

    localparam int N_COEFF = 256;
    localparam int D_MAX   = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    // Low d bits set; d above D_MAX saturates to all ones.
    function automatic logic [D_MAX-1:0] mask_d(input logic [3:0] d);
        logic [D_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < D_MAX; i++) begin
            m[i] = (i < int'(d));
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d: packs d-bit coefficients LSB-first into a byte stream,
// with valid/ready on both sides and d chosen per run.
module byte_encode_stream #(
    parameter int N_COEFF = kyber_pkg::N_COEFF,
    parameter int D_MAX   = kyber_pkg::D_MAX,
    parameter int ACC_W   = D_MAX + 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       d_sel,
    output logic             err,
    output logic             busy,
    output logic             done,
    input  logic             coeff_valid,
    output logic             coeff_ready,
    input  logic [D_MAX-1:0] coeff_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       byte_data
);

    import kyber_pkg::*;

    localparam int CNT_W = $clog2(N_COEFF + 1);

    enc_state_t       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [4:0]       fill_reg, fill_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       d_reg, d_next;
    logic             err_reg, err_next;

    logic             d_ok;
    logic             coeff_fire;
    logic             byte_fire;
    logic [D_MAX-1:0] masked;
    logic [ACC_W-1:0] ins;

    // Every output is a decode of registered state only.
    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);
    assign err         = err_reg;
    assign coeff_ready = (state_reg == ST_LOAD) && (fill_reg < 5'd8);
    assign byte_valid  = ((state_reg == ST_LOAD) || (state_reg == ST_DRAIN)) && (fill_reg >= 5'd8);
    assign byte_data   = acc_reg[7:0];

    assign coeff_fire = coeff_ready && coeff_valid;
    assign byte_fire  = byte_valid && byte_ready;
    assign d_ok       = (d_sel != 4'd0) && (int'(d_sel) <= D_MAX);
    assign masked     = coeff_data & D_MAX'(mask_d(d_reg));
    assign ins        = ACC_W'(masked) << fill_reg;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        fill_next  = fill_reg;
        cnt_next   = cnt_reg;
        d_next     = d_reg;
        err_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (d_ok) begin
                        d_next     = d_sel;
                        acc_next   = '0;
                        fill_next  = '0;
                        cnt_next   = '0;
                        state_next = ST_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (coeff_fire) begin
                    acc_next  = acc_reg | ins;
                    fill_next = fill_reg + 5'(d_reg);
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(N_COEFF - 1)) begin
                        state_next = ST_DRAIN;
                    end
                end else if (byte_fire) begin
                    acc_next  = acc_reg >> 8;
                    fill_next = fill_reg - 5'd8;
                end
            end
            ST_DRAIN: begin
                // Leave as the last byte goes so done follows that handshake by one cycle.
                if (byte_fire) begin
                    acc_next  = acc_reg >> 8;
                    fill_next = fill_reg - 5'd8;
                    if (fill_reg == 5'd8) begin
                        state_next = ST_DONE;
                    end
                end else if (fill_reg == 5'd0) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            fill_reg  <= '0;
            cnt_reg   <= '0;
            d_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            fill_reg  <= fill_next;
            cnt_reg   <= cnt_next;
            d_reg     <= d_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Scenario bench for byte_encode_stream: a bit-level reference model fills a byte
// scoreboard per run and each accepted output byte is popped and compared.
module tb_byte_encode_stream;

    localparam int N  = 256;
    localparam int DM = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    d_sel = 4'd0;
    logic          err, busy, done;
    logic          coeff_valid = 1'b0;
    logic          coeff_ready;
    logic [DM-1:0] coeff_data = '0;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic [7:0]    byte_data;

    int total = 0;
    int bad   = 0;

    logic [DM-1:0] coeffs [N];
    logic [7:0]    cap [N*DM/8];

    always #5 clk = ~clk;

    byte_encode_stream dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .d_sel       (d_sel),
        .err         (err),
        .busy        (busy),
        .done        (done),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .coeff_data  (coeff_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data)
    );

    // Stream bit k is bit (k mod d) of coefficient k/d; output byte i holds bits 8i..8i+7.
    function automatic logic [7:0] model_byte(input int i, input int d);
        logic [7:0]    r;
        logic [DM-1:0] c;
        int            k;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            k    = 8 * i + j;
            c    = coeffs[k / d];
            r[j] = c[k % d];
        end
        return r;
    endfunction

    task automatic check_idle_outputs(input string name);
        total++;
        if (coeff_ready !== 1'b0 || byte_valid !== 1'b0 || byte_data !== 8'h00 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s: got ready=%b bv=%b data=%h busy=%b done=%b err=%b, need all zero",
                     name, coeff_ready, byte_valid, byte_data, busy, done, err);
        end
    endtask

    // One full run with d; stall_pct = % of cycles byte_ready is low; abort_at>0 resets
    // after that many coefficients; restart_at>=0 pulses start(d_sel=5) mid-run.
    task automatic run_stream(input int d, input int stall_pct, input bit cadence,
                              input int abort_at, input int restart_at, input string name);
        logic [7:0] exp_q [$];
        logic [7:0] held;
        logic [7:0] got;
        int  idx = 0;
        int  cyc = 0;
        int  nbytes = 0;
        int  ndone = 0;
        int  last_fire = -1;
        int  prev_fire = -1;
        bit  stalled = 1'b0;
        bit  finished = 1'b0;
        bit  overlap = 1'b0;

        held = '0;
        for (int i = 0; i < N * d / 8; i++) exp_q.push_back(model_byte(i, d));

        @(negedge clk);
        start = 1'b1;
        d_sel = 4'(d);

        while (!finished && cyc < 20000) begin
            @(negedge clk);
            start = (cyc == restart_at);
            d_sel = (cyc == restart_at) ? 4'd5 : 4'(d);

            if (abort_at > 0 && idx == abort_at) begin
                coeff_valid = 1'b0;
                byte_ready  = 1'b0;
                rst = 1'b1;
                #1;
                check_idle_outputs({name, "_abort"});
                @(negedge clk);
                rst = 1'b0;
                return;
            end

            if (cyc == 0) begin
                total++;
                if (busy !== 1'b1 || coeff_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_start: busy=%b coeff_ready=%b, need 1 1", name, busy, coeff_ready);
                end
            end

            if (done === 1'b1) begin
                ndone++;
                total++;
                if (cyc != last_fire + 1 || exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL %s_done: done at cyc %0d (last byte %0d) left=%0d, need cyc %0d left=0",
                             name, cyc, last_fire, exp_q.size(), last_fire + 1);
                end
                finished = 1'b1;
            end

            if (coeff_ready === 1'b1 && byte_valid === 1'b1) overlap = 1'b1;

            if (stalled) begin
                total++;
                if (byte_data !== held || byte_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_stall: data=%h valid=%b, need %h 1", name, byte_data, byte_valid, held);
                end
            end

            coeff_valid = (idx < N);
            coeff_data  = (idx < N) ? coeffs[idx] : '0;
            byte_ready  = ($urandom_range(99) >= stall_pct);

            if (coeff_ready && coeff_valid) idx++;
            if (byte_valid && byte_ready) begin
                got = byte_data;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s_byte%0d: got %h, need no byte", name, nbytes, got);
                end else begin
                    if (got !== exp_q[0]) begin
                        bad++;
                        $display("FAIL %s_byte%0d: got %h need %h", name, nbytes, got, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (nbytes < N * DM / 8) cap[nbytes] = got;
                if (cadence && prev_fire >= 0) begin
                    total++;
                    if (cyc - prev_fire != 9) begin
                        bad++;
                        $display("FAIL %s_cadence: byte gap %0d cycles, need 9", name, cyc - prev_fire);
                    end
                end
                prev_fire = cyc;
                last_fire = cyc;
                nbytes++;
            end
            stalled = byte_valid && !byte_ready;
            held    = byte_data;
            cyc++;
        end

        coeff_valid = 1'b0;
        byte_ready  = 1'b0;
        start       = 1'b0;

        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
        end
        total++;
        if (nbytes != N * d / 8) begin
            bad++;
            $display("FAIL %s_count: got %0d bytes need %0d", name, nbytes, N * d / 8);
        end
        total++;
        if (overlap) begin
            bad++;
            $display("FAIL %s_overlap: coeff_ready=1 with byte_valid=1, need exclusive", name);
        end

        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s_after: busy=%b done=%b, need 0 0", name, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL %s_donecnt: got %0d done pulses need 1", name, ndone);
        end
        $display("run %s d=%0d bytes=%0d", name, d, nbytes);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) coeffs[i] = DM'($urandom);
    endtask

    task automatic test_reset();
        #2;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic test_d12();
        fill_random();
        coeffs[0] = 12'h123;
        coeffs[1] = 12'h456;
        run_stream(12, 0, 1'b0, 0, -1, "d12");
        total++;
        if (cap[0] !== 8'h23 || cap[1] !== 8'h61 || cap[2] !== 8'h45) begin
            bad++;
            $display("FAIL d12_first: got %h %h %h need 23 61 45", cap[0], cap[1], cap[2]);
        end
    endtask

    task automatic test_d4_mask();
        fill_random();
        coeffs[0] = 12'h001;
        coeffs[1] = 12'h002;
        coeffs[2] = 12'hFF3;
        coeffs[3] = 12'h004;
        run_stream(4, 0, 1'b0, 0, -1, "d4");
        total++;
        if (cap[0] !== 8'h21 || cap[1] !== 8'h43) begin
            bad++;
            $display("FAIL d4_first: got %h %h need 21 43", cap[0], cap[1]);
        end
    endtask

    task automatic test_d1_cadence();
        int nbad = 0;
        for (int i = 0; i < N; i++) coeffs[i] = (i % 2 == 0) ? DM'(1) : DM'(0);
        run_stream(1, 0, 1'b1, 0, -1, "d1");
        for (int i = 0; i < 32; i++) if (cap[i] !== 8'h55) nbad++;
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL d1_pattern: %0d bytes differ from 55, need 0", nbad);
        end
    endtask

    task automatic test_backpressure();
        fill_random();
        run_stream(10, 30, 1'b0, 0, -1, "d10_bp");
    endtask

    task automatic test_err();
        logic [3:0] bad_d [2];
        bad_d[0] = 4'd0;
        bad_d[1] = 4'd13;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1'b1;
            d_sel = bad_d[t];
            @(negedge clk);
            start = 1'b0;
            total++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL err_pulse d=%0d: err=%b busy=%b, need 1 0", bad_d[t], err, busy);
            end
            @(negedge clk);
            check_idle_outputs("err_after");
            $display("err check d_sel=%0d", bad_d[t]);
        end
    endtask

    task automatic test_start_busy();
        fill_random();
        run_stream(4, 10, 1'b0, 0, 10, "d4_restart");
    endtask

    task automatic test_rst_midrun();
        fill_random();
        run_stream(10, 0, 1'b0, 100, -1, "d10_abort");
        fill_random();
        run_stream(10, 0, 1'b0, 0, -1, "d10_after_rst");
    endtask

    initial begin
        test_reset();
        test_d12();
        test_d4_mask();
        test_d1_cadence();
        test_backpressure();
        test_err();
        test_start_busy();
        test_rst_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
